// File: rtl/m_unit_iter_if.sv
// rtl/m_unit_iter_if.sv - PCPI bus between the core and the M-extension unit
interface m_unit_iter_if #(
  parameter int XLEN = 32
) ();
  logic            pcpi_valid;
  logic [31:0]     pcpi_insn;
  logic [XLEN-1:0] pcpi_rs1;
  logic [XLEN-1:0] pcpi_rs2;
  logic            pcpi_wr;
  logic [XLEN-1:0] pcpi_rd;
  logic            pcpi_busy;
  logic            pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready
  );
endinterface

// File: rtl/m_unit_iter.sv
// rtl/m_unit_iter.sv - RISC-V M-extension PCPI unit: single-pass multiplier, radix-2^DIV_BITS divider
module m_unit_iter #(
  parameter int         XLEN     = 32,
  parameter int         DIV_BITS = 1,
  parameter logic [6:0] OPCODE   = 7'b0110011,
  parameter logic [6:0] FUNC7    = 7'b0000001
) (
  input logic          clk,
  input logic          resetn,
  m_unit_iter_if.slave pcpi
);

  localparam int             N       = XLEN / DIV_BITS;
  localparam int             CW      = $clog2(N + 1);
  localparam logic [CW-1:0]  LP_LAST = CW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [2:0]          r_func3;
  logic                r_sign_a;
  logic                r_sign_b;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [2*XLEN-1:0]   r_prod;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_rd;

  logic                w_match;
  logic                w_accept;
  logic [2:0]          w_f3;
  logic                w_neg_a;
  logic                w_neg_b;
  logic [XLEN-1:0]     w_abs_a;
  logic [XLEN-1:0]     w_abs_b;
  logic                w_b_zero;
  logic                w_ovf;
  logic                w_fast;
  logic [XLEN-1:0]     w_fast_rd;
  logic [2*XLEN-1:0]   w_ext_a;
  logic [2*XLEN-1:0]   w_ext_b;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_rem_n;
  logic [XLEN-1:0]     w_quo_n;
  logic [XLEN:0]       w_trial;
  logic [XLEN-1:0]     w_fix_rd;
  logic                w_busy;
  logic                w_ready;
  logic                w_unused_insn;

  // Register-number fields are irrelevant to the unit.
  assign w_unused_insn = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  assign w_f3     = pcpi.pcpi_insn[14:12];
  assign w_match  = (pcpi.pcpi_insn[6:0] == OPCODE) && (pcpi.pcpi_insn[31:25] == FUNC7);
  assign w_accept = (r_state == S_IDLE) && pcpi.pcpi_valid && w_match;

  // Sign of rs1 matters for MULH/MULHSU/DIV/REM, sign of rs2 for MULH/DIV/REM.
  assign w_neg_a = pcpi.pcpi_rs1[XLEN-1] &&
                   ((w_f3 == 3'd1) || (w_f3 == 3'd2) || (w_f3 == 3'd4) || (w_f3 == 3'd6));
  assign w_neg_b = pcpi.pcpi_rs2[XLEN-1] &&
                   ((w_f3 == 3'd1) || (w_f3 == 3'd4) || (w_f3 == 3'd6));
  assign w_abs_a = w_neg_a ? ({XLEN{1'b0}} - pcpi.pcpi_rs1) : pcpi.pcpi_rs1;
  assign w_abs_b = w_neg_b ? ({XLEN{1'b0}} - pcpi.pcpi_rs2) : pcpi.pcpi_rs2;

  assign w_b_zero = (pcpi.pcpi_rs2 == {XLEN{1'b0}});
  assign w_ovf    = !w_f3[0] &&
                    (pcpi.pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (pcpi.pcpi_rs2 == {XLEN{1'b1}});
  assign w_fast   = w_f3[2] && (w_b_zero || w_ovf);

  always_comb begin
    w_fast_rd = {XLEN{1'b0}};
    if (w_b_zero) begin
      w_fast_rd = w_f3[1] ? pcpi.pcpi_rs1 : {XLEN{1'b1}};
    end else begin
      w_fast_rd = w_f3[1] ? {XLEN{1'b0}} : pcpi.pcpi_rs1;
    end
  end

  // The recorded sign bits double as the extension bits of the product operands.
  assign w_ext_a = {{XLEN{r_sign_a}}, r_a};
  assign w_ext_b = {{XLEN{r_sign_b}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_comb begin
    w_rem_n = r_rem;
    w_quo_n = r_quo;
    w_trial = {(XLEN+1){1'b0}};
    for (int k = 0; k < DIV_BITS; k++) begin
      w_trial = {w_rem_n, w_quo_n[XLEN-1]};
      w_quo_n = {w_quo_n[XLEN-2:0], 1'b0};
      if (w_trial >= {1'b0, r_b}) begin
        w_trial    = w_trial - {1'b0, r_b};
        w_quo_n[0] = 1'b1;
      end
      w_rem_n = w_trial[XLEN-1:0];
    end
  end

  always_comb begin
    w_fix_rd = {XLEN{1'b0}};
    if (!r_func3[2]) begin
      w_fix_rd = (r_func3 == 3'd0) ? r_prod[XLEN-1:0] : r_prod[2*XLEN-1:XLEN];
    end else if (!r_func3[1]) begin
      w_fix_rd = (r_sign_a ^ r_sign_b) ? ({XLEN{1'b0}} - r_quo) : r_quo;
    end else begin
      w_fix_rd = r_sign_a ? ({XLEN{1'b0}} - r_rem) : r_rem;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_busy    = 1'b0;
    w_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_fast)         w_state_n = S_DONE;
          else if (w_f3[2])   w_state_n = S_DIV;
          else                w_state_n = S_MUL;
        end
      end
      S_MUL: begin
        w_busy    = 1'b1;
        w_state_n = pcpi.pcpi_valid ? S_FIX : S_IDLE;
      end
      S_DIV: begin
        w_busy = 1'b1;
        if (!pcpi.pcpi_valid)       w_state_n = S_IDLE;
        else if (r_cnt == LP_LAST)  w_state_n = S_FIX;
      end
      S_FIX: begin
        w_busy    = 1'b1;
        w_state_n = pcpi.pcpi_valid ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        w_ready   = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_func3  <= 3'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= {XLEN{1'b0}};
      r_b      <= {XLEN{1'b0}};
      r_rem    <= {XLEN{1'b0}};
      r_quo    <= {XLEN{1'b0}};
      r_prod   <= {(2*XLEN){1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_rd     <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func3  <= w_f3;
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_a      <= pcpi.pcpi_rs1;
            r_b      <= w_f3[2] ? w_abs_b : pcpi.pcpi_rs2;
            r_quo    <= w_abs_a;
            r_rem    <= {XLEN{1'b0}};
            r_cnt    <= {CW{1'b0}};
            if (w_fast) r_rd <= w_fast_rd;
          end
        end
        S_MUL: r_prod <= w_prod;
        S_DIV: begin
          if (pcpi.pcpi_valid) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (pcpi.pcpi_valid) r_rd <= w_fix_rd;
        end
        S_DONE: r_func3 <= 3'd0;
        default: ;
      endcase
    end
  end

  assign pcpi.pcpi_busy  = w_busy;
  assign pcpi.pcpi_ready = w_ready;
  assign pcpi.pcpi_wr    = w_ready;
  assign pcpi.pcpi_rd    = r_rd;

endmodule

// File: tb/tb_m_unit_iter.sv
// tb/tb_m_unit_iter.sv - directed and reference-model bench for m_unit_iter (DIV_BITS 1 and 4)
module tb_m_unit_iter;

  localparam logic [6:0] OPC = 7'b0110011;
  localparam logic [6:0] F7  = 7'b0000001;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;
  int   g_sel;

  logic        s_ready;
  logic        s_busy;
  logic        s_wr;
  logic [31:0] s_rd;

  m_unit_iter_if #(.XLEN(32)) u_if0 ();
  m_unit_iter_if #(.XLEN(32)) u_if1 ();

  m_unit_iter #(.XLEN(32), .DIV_BITS(1)) u_dut0 (.clk(clk), .resetn(resetn), .pcpi(u_if0));
  m_unit_iter #(.XLEN(32), .DIV_BITS(4)) u_dut1 (.clk(clk), .resetn(resetn), .pcpi(u_if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_ready = (g_sel == 1) ? u_if1.pcpi_ready : u_if0.pcpi_ready;
    s_busy  = (g_sel == 1) ? u_if1.pcpi_busy  : u_if0.pcpi_busy;
    s_wr    = (g_sel == 1) ? u_if1.pcpi_wr    : u_if0.pcpi_wr;
    s_rd    = (g_sel == 1) ? u_if1.pcpi_rd    : u_if0.pcpi_rd;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  task automatic drive(input int sel, input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b, input logic valid);
    u_if0.pcpi_insn  = insn;
    u_if0.pcpi_rs1   = a;
    u_if0.pcpi_rs2   = b;
    u_if0.pcpi_valid = valid && (sel == 0);
    u_if1.pcpi_insn  = insn;
    u_if1.pcpi_rs1   = a;
    u_if1.pcpi_rs2   = b;
    u_if1.pcpi_valid = valid && (sel == 1);
  endtask

  // Called just after a negedge; returns with the unit back in IDLE.
  task automatic run_op(input int sel, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] rd, output int lat,
                        output int busy_n, output logic wr);
    g_sel = sel;
    drive(sel, mk_insn(F7, f3, OPC), a, b, 1'b1);
    lat = 0; busy_n = 0; rd = '0; wr = 1'b0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      if (s_busy) busy_n++;
      if (s_ready) begin
        lat = c; rd = s_rd; wr = s_wr;
      end
    end
    drive(sel, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    logic        ovf;
    sa  = a; sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = {32'h0, a}; eb = {32'h0, b};
    if (f3 == 3'd1 || f3 == 3'd2) ea = {{32{a[31]}}, a};
    if (f3 == 3'd1) eb = {{32{b[31]}}, b};
    p = ea * eb;
    case (f3)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  typedef struct {
    int          sel;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr;
    int          lat;
    int          busy_n;
    int          rdy_seen;
    int          busy_seen;

    errors = 0; checks = 0; g_sel = 0;
    resetn = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst busy0",  {63'd0, u_if0.pcpi_busy},  64'd0);
    chk("rst ready0", {63'd0, u_if0.pcpi_ready}, 64'd0);
    chk("rst wr0",    {63'd0, u_if0.pcpi_wr},    64'd0);
    chk("rst rd0",    {32'd0, u_if0.pcpi_rd},    64'd0);
    chk("rst rd1",    {32'd0, u_if1.pcpi_rd},    64'd0);
    resetn = 1'b1;
    @(negedge clk);

    vecs = '{
      '{0, 3'd0, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 3},
      '{0, 3'd3, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 3},
      '{0, 3'd1, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 3},
      '{0, 3'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 3},
      '{0, 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 3},
      '{0, 3'd4, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34},
      '{0, 3'd6, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34},
      '{0, 3'd5, 32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC, 34},
      '{0, 3'd7, 32'hFFFF_FFF9, 32'h2,         32'h0000_0001, 34},
      '{0, 3'd5, 32'h5,         32'h0,         32'hFFFF_FFFF, 1},
      '{0, 3'd6, 32'h5,         32'h0,         32'h0000_0005, 1},
      '{0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
      '{0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1},
      '{1, 3'd5, 32'd100,       32'd7,         32'd14,        10},
      '{1, 3'd7, 32'd100,       32'd7,         32'd2,         10}
    };
    foreach (vecs[i]) begin
      run_op(vecs[i].sel, vecs[i].f3, vecs[i].a, vecs[i].b, rd, lat, busy_n, wr);
      chk($sformatf("vec%0d rd", i),  {32'd0, rd}, {32'd0, vecs[i].exp});
      chk($sformatf("vec%0d lat", i), 64'(lat),    64'(vecs[i].lat));
      chk($sformatf("vec%0d busy", i), 64'(busy_n), 64'(vecs[i].lat - 1));
      chk($sformatf("vec%0d wr", i),  {63'd0, wr}, 64'd1);
    end

    // Abort: drop pcpi_valid during cycle T+5 of a DIV, then issue MUL 3x4.
    g_sel = 0;
    drive(0, mk_insn(F7, 3'd4, OPC), 32'd1000, 32'd3, 1'b1);
    rdy_seen = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (s_ready) rdy_seen++;
    end
    chk("abort busy T+5", {63'd0, s_busy}, 64'd1);
    drive(0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("abort busy T+6",  {63'd0, s_busy},  64'd0);
    chk("abort ready T+6", {63'd0, s_ready}, 64'd0);
    chk("abort no ready",  64'(rdy_seen),    64'd0);
    chk("abort rd hold",   {32'd0, s_rd},    64'h0000_0000);
    run_op(0, 3'd0, 32'd3, 32'd4, rd, lat, busy_n, wr);
    chk("abort mul rd",  {32'd0, rd}, 64'd12);
    chk("abort mul lat", 64'(lat),    64'd3);

    // Async reset at T+10 of a DIV.
    drive(0, mk_insn(F7, 3'd5, OPC), 32'd1000, 32'd3, 1'b1);
    repeat (10) @(negedge clk);
    chk("pre-rst busy", {63'd0, s_busy}, 64'd1);
    resetn = 1'b0;
    #1;
    chk("mid-rst busy",  {63'd0, u_if0.pcpi_busy},  64'd0);
    chk("mid-rst ready", {63'd0, u_if0.pcpi_ready}, 64'd0);
    chk("mid-rst rd",    {32'd0, u_if0.pcpi_rd},    64'd0);
    drive(0, 32'h0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    rdy_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (s_ready || s_busy) rdy_seen++;
    end
    chk("post-rst quiet", 64'(rdy_seen), 64'd0);

    // Non-matching funct7 and opcode must be ignored.
    drive(0, mk_insn(7'b0000000, 3'd0, OPC), 32'd3, 32'd4, 1'b1);
    busy_seen = 0; rdy_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (s_busy) busy_seen++;
      if (s_ready) rdy_seen++;
    end
    drive(0, mk_insn(F7, 3'd4, 7'b0110111), 32'd9, 32'd2, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (s_busy) busy_seen++;
      if (s_ready) rdy_seen++;
    end
    drive(0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("illegal busy",  64'(busy_seen), 64'd0);
    chk("illegal ready", 64'(rdy_seen),  64'd0);

    // Reference-model sweep on the radix-16 instance.
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 100; i++) begin
        a = (i % 10 == 0) ? 32'h8000_0000 : $urandom;
        case (i % 4)
          0: b = $urandom;
          1: b = $urandom_range(1, 255);
          2: b = $urandom_range(0, 3);
          default: b = ~$urandom_range(0, 3);
        endcase
        run_op(1, 3'(f), a, b, rd, lat, busy_n, wr);
        chk($sformatf("rnd f3=%0d a=%h b=%h", f, a, b), {32'd0, rd}, {32'd0, ref_m(3'(f), a, b)});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
